// File: rtl/fm_demod_mc.sv
// fm_demod_mc: multi-channel FM discriminator.
// Samples tagged with a channel index are queued in an input FIFO. A
// sequential core forms the conjugate product with that channel's previous
// sample, computes a quantised arctangent with a restoring divider, applies
// a gain, and pushes the result into a first-word-fall-through output FIFO.
module fm_demod_mc #(
   parameter int DATA_WIDTH   = 32,
   parameter int FRAC_BITS    = 10,
   parameter int NUM_CHANNELS = 4,
   parameter int IN_DEPTH     = 16,
   parameter int OUT_DEPTH    = 16,
   parameter int QUAD1        = 804,
   parameter int QUAD3        = 2412,
   parameter int GAIN         = 758,
   localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] real_in,
   input  logic [DATA_WIDTH-1:0] imag_in,
   input  logic [CW-1:0]         in_chan,
   input  logic                  in_fifo_wr_en,
   output logic                  in_fifos_full,
   input  logic                  out_fifo_rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [CW-1:0]         chan_out,
   output logic                  out_fifo_empty
);
   localparam int DW   = DATA_WIDTH;
   localparam int NW   = DW + FRAC_BITS;   // dividend width
   localparam int Q    = NW;               // quotient bits = divider cycles
   localparam int CNTW = $clog2(Q);
   localparam int IAW  = $clog2(IN_DEPTH);
   localparam int OAW  = $clog2(OUT_DEPTH);
   localparam int IEW  = CW + 2 * DW;
   localparam int OEW  = CW + DW;
   localparam logic signed [DW-1:0] ONE = 1;
   localparam logic signed [DW-1:0] Q1  = DW'(QUAD1);
   localparam logic signed [DW-1:0] Q3  = DW'(QUAD3);
   localparam logic signed [DW-1:0] G   = DW'(GAIN);

   typedef enum logic [2:0] {S_IDLE, S_MULT, S_PREP, S_DIV, S_ANGLE, S_GAIN, S_WRITE} state_t;

   // ---------------- input FIFO ----------------
   logic [IEW-1:0] in_mem_q [IN_DEPTH];
   logic [IAW:0]   in_wr_q, in_rd_q;
   logic           in_empty, in_full, in_push, in_pop;
   logic [IEW-1:0] in_head;

   // ---------------- output FIFO ----------------
   logic [OEW-1:0] out_mem_q [OUT_DEPTH];
   logic [OAW:0]   out_wr_q, out_rd_q;
   logic           out_empty, out_full, out_push, out_pop;
   logic [OEW-1:0] out_head;

   // ---------------- core ----------------
   state_t                 state_q, state_d;
   logic [CNTW-1:0]        cnt_q, cnt_d;
   logic [CW-1:0]          ch_q, ch_d, hidx;
   logic signed [DW-1:0]   cr_q, cr_d, ci_q, ci_d;
   logic signed [DW-1:0]   re_q, re_d, im_q, im_d;
   logic signed [DW-1:0]   base_q, base_d, ang_q, ang_d, y_q, y_d;
   logic [DW-1:0]          den_q, den_d, rem_q, rem_d;
   logic [NW-1:0]          dvd_q, dvd_d;
   logic                   neg_q, neg_d, hist_we;
   logic signed [DW-1:0]   hist_re_q [NUM_CHANNELS];
   logic signed [DW-1:0]   hist_im_q [NUM_CHANNELS];

   logic signed [DW-1:0]    pr, pi, abs_y, diff, den_c, ang_c;
   logic signed [2*DW-1:0]  p_re, p_im, prod_g;
   logic [NW-1:0]           num, num_mag;
   logic [DW:0]             rem_sh;
   logic signed [NW-1:0]    qs, r_s;
   logic signed [NW+DW-1:0] prod_a;

   assign in_empty = (in_wr_q == in_rd_q);
   assign in_full  = (in_wr_q[IAW] != in_rd_q[IAW]) && (in_wr_q[IAW-1:0] == in_rd_q[IAW-1:0]);
   assign in_pop   = (state_q == S_IDLE) && !in_empty;
   assign in_push  = in_fifo_wr_en && (!in_full || in_pop);
   assign in_head  = in_mem_q[in_rd_q[IAW-1:0]];

   assign out_empty = (out_wr_q == out_rd_q);
   assign out_full  = (out_wr_q[OAW] != out_rd_q[OAW]) && (out_wr_q[OAW-1:0] == out_rd_q[OAW-1:0]);
   assign out_pop   = out_fifo_rd_en && !out_empty;
   assign out_push  = (state_q == S_WRITE) && (!out_full || out_pop);
   assign out_head  = out_mem_q[out_rd_q[OAW-1:0]];

   assign in_fifos_full  = in_full;
   assign out_fifo_empty = out_empty;
   assign data_out       = out_empty ? '0 : out_head[DW-1:0];
   assign chan_out       = out_empty ? '0 : out_head[OEW-1 -: CW];

   // Datapath arithmetic shared by the core states
   assign hidx    = CW'(ch_q % NUM_CHANNELS);
   assign pr      = hist_re_q[hidx];
   assign pi      = hist_im_q[hidx];
   assign p_re    = pr * cr_q + pi * ci_q;
   assign p_im    = pr * ci_q - pi * cr_q;
   assign abs_y   = (im_q[DW-1] ? -im_q : im_q) + ONE;
   assign diff    = re_q[DW-1] ? (re_q + abs_y) : (re_q - abs_y);
   assign den_c   = re_q[DW-1] ? (abs_y - re_q) : (re_q + abs_y);
   assign num     = {diff, {FRAC_BITS{1'b0}}};
   assign num_mag = diff[DW-1] ? (~num + 1'b1) : num;
   assign rem_sh  = {rem_q, dvd_q[NW-1]};
   assign qs      = signed'(dvd_q);
   assign r_s     = neg_q ? -qs : qs;
   assign prod_a  = Q1 * r_s;
   assign ang_c   = base_q - DW'(prod_a >>> FRAC_BITS);
   assign prod_g  = G * ang_q;

   // Input FIFO storage and pointers
   always_ff @(posedge clk) begin
      if (in_push) in_mem_q[in_wr_q[IAW-1:0]] <= {in_chan, real_in, imag_in};
      if (reset) begin
         in_wr_q <= '0;
         in_rd_q <= '0;
      end else begin
         if (in_push) in_wr_q <= in_wr_q + 1'b1;
         if (in_pop)  in_rd_q <= in_rd_q + 1'b1;
      end
   end

   // Output FIFO storage and pointers
   always_ff @(posedge clk) begin
      if (out_push) out_mem_q[out_wr_q[OAW-1:0]] <= {ch_q, y_q};
      if (reset) begin
         out_wr_q <= '0;
         out_rd_q <= '0;
      end else begin
         if (out_push) out_wr_q <= out_wr_q + 1'b1;
         if (out_pop)  out_rd_q <= out_rd_q + 1'b1;
      end
   end

   // Core next-state and datapath next-values
   always_comb begin
      state_d = state_q;  cnt_d  = cnt_q;   ch_d  = ch_q;   cr_d  = cr_q;
      ci_d    = ci_q;     re_d   = re_q;    im_d  = im_q;   base_d = base_q;
      den_d   = den_q;    rem_d  = rem_q;   dvd_d = dvd_q;  neg_d = neg_q;
      ang_d   = ang_q;    y_d    = y_q;     hist_we = 1'b0;
      case (state_q)
         S_IDLE: if (!in_empty) begin
            ch_d    = in_head[IEW-1 -: CW];
            cr_d    = in_head[2*DW-1:DW];
            ci_d    = in_head[DW-1:0];
            state_d = S_MULT;
         end
         S_MULT: begin
            re_d    = DW'(p_re >>> FRAC_BITS);
            im_d    = DW'(p_im >>> FRAC_BITS);
            hist_we = 1'b1;
            state_d = S_PREP;
         end
         S_PREP: begin
            base_d  = re_q[DW-1] ? Q3 : Q1;
            den_d   = den_c;
            neg_d   = diff[DW-1];
            dvd_d   = num_mag;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_DIV;
         end
         S_DIV: begin
            if (rem_sh >= {1'b0, den_q}) begin
               rem_d = DW'(rem_sh - {1'b0, den_q});
               dvd_d = {dvd_q[NW-2:0], 1'b1};
            end else begin
               rem_d = rem_sh[DW-1:0];
               dvd_d = {dvd_q[NW-2:0], 1'b0};
            end
            if (cnt_q == CNTW'(Q - 1)) state_d = S_ANGLE;
            else                       cnt_d   = cnt_q + 1'b1;
         end
         S_ANGLE: begin
            ang_d   = im_q[DW-1] ? -ang_c : ang_c;
            state_d = S_GAIN;
         end
         S_GAIN: begin
            y_d     = DW'(prod_g >>> FRAC_BITS);
            state_d = S_WRITE;
         end
         S_WRITE: if (out_push) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Core control registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Core data registers; in-flight values are don't-care once the FSM idles
   always_ff @(posedge clk) begin
      ch_q <= ch_d;   cr_q <= cr_d;   ci_q <= ci_d;   re_q <= re_d;
      im_q <= im_d;   base_q <= base_d;   den_q <= den_d;   rem_q <= rem_d;
      dvd_q <= dvd_d; neg_q <= neg_d; ang_q <= ang_d; y_q <= y_d;
   end

   // Per-channel previous-sample history
   always_ff @(posedge clk) begin
      if (reset) begin
         hist_re_q <= '{default: '0};
         hist_im_q <= '{default: '0};
      end else if (hist_we) begin
         hist_re_q[hidx] <= cr_q;
         hist_im_q[hidx] <= ci_q;
      end
   end
endmodule

// File: tb/tb_fm_demod_mc.sv
// Directed bench for fm_demod_mc with hand-computed expected outputs.
module tb_fm_demod_mc;
   localparam int DW = 32;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] real_in, imag_in;
   logic [CW-1:0] in_chan;
   logic          in_fifo_wr_en, in_fifos_full, out_fifo_rd_en, out_fifo_empty;
   logic [DW-1:0] data_out;
   logic [CW-1:0] chan_out;

   int errors = 0;
   int checks = 0;
   bit saw_full;

   localparam logic [DW-1:0] V1190 = 32'd1190;
   localparam logic [DW-1:0] VONE  = 32'd1;
   localparam logic [DW-1:0] VNEG  = 32'hFFFFFB59;   // -1191
   localparam logic [DW-1:0] V2379 = 32'd2379;

   fm_demod_mc dut (
      .clk(clk), .reset(reset), .real_in(real_in), .imag_in(imag_in),
      .in_chan(in_chan), .in_fifo_wr_en(in_fifo_wr_en), .in_fifos_full(in_fifos_full),
      .out_fifo_rd_en(out_fifo_rd_en), .data_out(data_out), .chan_out(chan_out),
      .out_fifo_empty(out_fifo_empty)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
   endtask

   task automatic push(input logic [CW-1:0] ch, input int re, input int im);
      int n = 0;
      while (in_fifos_full && n < 300) begin saw_full = 1'b1; tick(); n++; end
      if (in_fifos_full) begin
         checks++; errors++;
         $display("FAIL push_wait: in_fifos_full stuck at %0b, required 0", in_fifos_full);
      end else begin
         in_chan = ch; real_in = DW'(re); imag_in = DW'(im); in_fifo_wr_en = 1'b1;
         tick();
         in_fifo_wr_en = 1'b0;
      end
   endtask

   // Waits (bounded) for a word, captures the head and pops it; x on timeout.
   task automatic pop_word(output logic [DW-1:0] d, output logic [CW-1:0] c);
      int n = 0;
      while (out_fifo_empty && n < 200) begin tick(); n++; end
      if (out_fifo_empty) begin
         d = 'x; c = 'x;
      end else begin
         d = data_out; c = chan_out;
         out_fifo_rd_en = 1'b1; tick(); out_fifo_rd_en = 1'b0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", out_fifo_empty); end
      checks++; if (in_fifos_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", in_fifos_full); end
      checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
      checks++; if (chan_out !== '0) begin errors++; $display("FAIL reset_chan: got %0d want 0", chan_out); end
   endtask

   task automatic test_latency();
      logic [DW-1:0] d; logic [CW-1:0] c;
      do_reset();
      push(0, 1024, 0);
      for (int i = 0; i < 47; i++) tick();
      checks++; if (out_fifo_empty !== 1'b1) begin errors++; $display("FAIL lat_early: empty=%0b want 1 after 47 edges", out_fifo_empty); end
      tick();
      checks++; if (out_fifo_empty !== 1'b0) begin errors++; $display("FAIL lat_48: empty=%0b want 0 after 48 edges", out_fifo_empty); end
      pop_word(d, c);
      checks++; if (d !== V1190) begin errors++; $display("FAIL lat_data: got %h want %h", d, V1190); end
      checks++; if (c !== 2'd0) begin errors++; $display("FAIL lat_chan: got %0d want 0", c); end
   endtask

   task automatic test_history();
      logic [DW-1:0] d; logic [CW-1:0] c;
      logic [DW-1:0] exp_d [4];
      logic [CW-1:0] exp_c [4];
      exp_d = '{V1190, VONE, V1190, V1190};
      exp_c = '{2'd0, 2'd0, 2'd0, 2'd1};
      do_reset();
      push(0, 1024, 0); push(0, 1024, 0); push(0, 0, 1024); push(1, 1024, 0);
      for (int i = 0; i < 4; i++) begin
         pop_word(d, c);
         checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL hist_data[%0d]: got %h want %h", i, d, exp_d[i]); end
         checks++; if (c !== exp_c[i]) begin errors++; $display("FAIL hist_chan[%0d]: got %0d want %0d", i, c, exp_c[i]); end
      end
   endtask

   task automatic test_negative();
      logic [DW-1:0] d; logic [CW-1:0] c;
      do_reset();
      push(0, 0, 1024); push(0, 1024, 0);
      pop_word(d, c);
      checks++; if (d !== V1190) begin errors++; $display("FAIL neg_first: got %h want %h", d, V1190); end
      pop_word(d, c);
      checks++; if (d !== VNEG) begin errors++; $display("FAIL neg_angle: got %h want %h", d, VNEG); end
      checks++; if (c !== 2'd0) begin errors++; $display("FAIL neg_chan: got %0d want 0", c); end
   endtask

   task automatic test_interleave();
      logic [DW-1:0] d; logic [CW-1:0] c;
      int            vre [9];
      int            vim [9];
      logic [DW-1:0] exp_d [9];
      vre   = '{1024, 0, 1024, 0, 1024, 1024, 0, 0, -1024};
      vim   = '{0, 1024, 0, 1024, 0, 0, 1024, 1024, 0};
      exp_d = '{V1190, V1190, V1190, V1190, VONE, VNEG, V1190, VONE, V2379};
      do_reset();
      for (int i = 0; i < 9; i++) push(CW'(i % 4), vre[i], vim[i]);
      for (int i = 0; i < 9; i++) begin
         pop_word(d, c);
         checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL mix_data[%0d]: got %h want %h", i, d, exp_d[i]); end
         checks++; if (c !== CW'(i % 4)) begin errors++; $display("FAIL mix_chan[%0d]: got %0d want %0d", i, c, i % 4); end
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] d; logic [CW-1:0] c;
      do_reset();
      saw_full = 1'b0;
      for (int i = 0; i < 19; i++) push(CW'(i % 4), 1024, 0);
      for (int i = 0; i < 900; i++) tick();
      checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL bp_full_seen: got %0b want 1", saw_full); end
      checks++; if (out_fifo_empty !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0b want 0", out_fifo_empty); end
      checks++; if (in_fifos_full !== 1'b0) begin errors++; $display("FAIL bp_in_full: got %0b want 0", in_fifos_full); end
      for (int i = 0; i < 19; i++) begin
         pop_word(d, c);
         checks++; if (d !== ((i < 4) ? V1190 : VONE)) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, d, (i < 4) ? V1190 : VONE); end
         checks++; if (c !== CW'(i % 4)) begin errors++; $display("FAIL bp_chan[%0d]: got %0d want %0d", i, c, i % 4); end
      end
      for (int i = 0; i < 60; i++) tick();
      checks++; if (out_fifo_empty !== 1'b1) begin errors++; $display("FAIL bp_extra: empty=%0b want 1", out_fifo_empty); end
   endtask

   task automatic test_reset_mid_div();
      logic [DW-1:0] d; logic [CW-1:0] c;
      do_reset();
      for (int i = 0; i < 6; i++) push(0, 1024, 0);
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1; tick();
      checks++; if (out_fifo_empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %0b want 1", out_fifo_empty); end
      checks++; if (in_fifos_full !== 1'b0) begin errors++; $display("FAIL mid_full: got %0b want 0", in_fifos_full); end
      reset = 1'b0; tick();
      push(0, 1024, 0);
      pop_word(d, c);
      checks++; if (d !== V1190) begin errors++; $display("FAIL mid_data: got %h want %h", d, V1190); end
      checks++; if (c !== 2'd0) begin errors++; $display("FAIL mid_chan: got %0d want 0", c); end
      for (int i = 0; i < 60; i++) tick();
      checks++; if (out_fifo_empty !== 1'b1) begin errors++; $display("FAIL mid_stale: empty=%0b want 1", out_fifo_empty); end
   endtask

   initial begin
      reset = 1'b1; real_in = '0; imag_in = '0; in_chan = '0;
      in_fifo_wr_en = 1'b0; out_fifo_rd_en = 1'b0; saw_full = 1'b0;
      test_reset();
      test_latency();
      test_history();
      test_negative();
      test_interleave();
      test_back_to_back();
      test_reset_mid_div();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
